// File: rtl/imul_share_arbiter_if.sv
// rtl/imul_share_arbiter_if.sv - val/rdy request and response channel bundles
interface imul_share_arbiter_req_if #(parameter int p_nbits = 32);
  logic                 val;
  logic                 rdy;
  logic [2*p_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

interface imul_share_arbiter_resp_if #(parameter int p_nbits = 32);
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/imul_share_arbiter.sv
// rtl/imul_share_arbiter.sv - round-robin sharing of one val/rdy multiplier between two requesters
module imul_share_arbiter #(
  parameter int p_nbits     = 32,
  parameter int p_cnt_nbits = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  imul_share_arbiter_req_if.slave       req0,
  imul_share_arbiter_req_if.slave       req1,
  imul_share_arbiter_resp_if.master     resp0,
  imul_share_arbiter_resp_if.master     resp1,
  imul_share_arbiter_req_if.master      mul_req,
  imul_share_arbiter_resp_if.slave      mul_resp,
  output logic [p_cnt_nbits-1:0]        o_cnt0,
  output logic [p_cnt_nbits-1:0]        o_cnt1
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [p_cnt_nbits-1:0] lp_cnt_one = 1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_owner;
  logic                   r_prio;
  logic [p_cnt_nbits-1:0] r_cnt0;
  logic [p_cnt_nbits-1:0] r_cnt1;
  logic                   w_grant;
  logic                   w_any;
  logic                   w_req_fire;
  logic                   w_resp_fire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) begin
        r_owner <= w_grant;
        r_prio  <= ~w_grant;
      end
      if (w_resp_fire) begin
        if (r_owner) r_cnt1 <= r_cnt1 + lp_cnt_one;
        else         r_cnt0 <= r_cnt0 + lp_cnt_one;
      end
    end
  end

  // Grant is re-evaluated every IDLE cycle; nothing is committed until the multiplier accepts.
  always_comb begin
    w_state_next = r_state;
    w_any        = req0.val | req1.val;
    w_grant      = (req0.val & req1.val) ? r_prio : req1.val;
    w_req_fire   = 1'b0;
    w_resp_fire  = 1'b0;
    req0.rdy     = 1'b0;
    req1.rdy     = 1'b0;
    mul_req.val  = 1'b0;
    mul_req.msg  = '0;
    mul_resp.rdy = 1'b0;
    resp0.val    = 1'b0;
    resp0.msg    = '0;
    resp1.val    = 1'b0;
    resp1.msg    = '0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          mul_req.val = 1'b1;
          mul_req.msg = w_grant ? req1.msg : req0.msg;
          if (w_grant) req1.rdy = mul_req.rdy;
          else         req0.rdy = mul_req.rdy;
        end
        w_req_fire = w_any & mul_req.rdy;
        if (w_req_fire) w_state_next = WAIT;
      end
      WAIT: begin
        if (r_owner) begin
          resp1.val    = mul_resp.val;
          resp1.msg    = mul_resp.msg;
          mul_resp.rdy = resp1.rdy;
          w_resp_fire  = mul_resp.val & resp1.rdy;
        end else begin
          resp0.val    = mul_resp.val;
          resp0.msg    = mul_resp.msg;
          mul_resp.rdy = resp0.rdy;
          w_resp_fire  = mul_resp.val & resp0.rdy;
        end
        if (w_resp_fire) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Handshakes are suppressed while reset is held so nothing fires across it.
    if (i_reset) begin
      req0.rdy     = 1'b0;
      req1.rdy     = 1'b0;
      mul_req.val  = 1'b0;
      mul_resp.rdy = 1'b0;
      resp0.val    = 1'b0;
      resp1.val    = 1'b0;
      w_req_fire   = 1'b0;
      w_resp_fire  = 1'b0;
    end
  end

  assign o_cnt0 = r_cnt0;
  assign o_cnt1 = r_cnt1;

endmodule

// File: tb/tb_imul_share_arbiter.sv
// tb/tb_imul_share_arbiter.sv - directed self-checking bench for imul_share_arbiter
module tb_imul_share_arbiter;

  localparam int lp_lat = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  imul_share_arbiter_req_if  #(.p_nbits(32)) req0_if ();
  imul_share_arbiter_req_if  #(.p_nbits(32)) req1_if ();
  imul_share_arbiter_req_if  #(.p_nbits(32)) mreq_if ();
  imul_share_arbiter_resp_if #(.p_nbits(32)) resp0_if ();
  imul_share_arbiter_resp_if #(.p_nbits(32)) resp1_if ();
  imul_share_arbiter_resp_if #(.p_nbits(32)) mresp_if ();

  imul_share_arbiter #(.p_nbits(32), .p_cnt_nbits(2)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .req0     (req0_if),
    .req1     (req1_if),
    .resp0    (resp0_if),
    .resp1    (resp1_if),
    .mul_req  (mreq_if),
    .mul_resp (mresp_if),
    .o_cnt0   (cnt0),
    .o_cnt1   (cnt1)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] mreq_log[$];
  logic [31:0] rx0[$];
  logic [31:0] rx1[$];
  logic        grants[$];
  logic [1:0]  cnt0_log[$];
  logic        rdy0 = 1'b1;
  logic        rdy1 = 1'b1;
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_prod;
  bit          seen_resp1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_if.val = (q0.size() > 0);
    req0_if.msg = 64'd0;
    if (q0.size() > 0) req0_if.msg = q0[0];
    req1_if.val = (q1.size() > 0);
    req1_if.msg = 64'd0;
    if (q1.size() > 0) req1_if.msg = q1[0];
    resp0_if.rdy = rdy0;
    resp1_if.rdy = rdy1;
    mreq_if.rdy  = !m_busy;
    mresp_if.val = m_busy && (m_cnt == 0);
    mresp_if.msg = m_prod;
  endtask

  // One clock: sample handshakes at the falling edge, update bench state after the rising edge.
  task automatic step();
    bit f_q0, f_q1, f_mq, f_mr, f_r0, f_r1;
    logic [63:0] mq_msg;
    logic [31:0] r0_msg, r1_msg;
    @(negedge clk);
    f_q0   = req0_if.val & req0_if.rdy;
    f_q1   = req1_if.val & req1_if.rdy;
    f_mq   = mreq_if.val & mreq_if.rdy;
    f_mr   = mresp_if.val & mresp_if.rdy;
    f_r0   = resp0_if.val & resp0_if.rdy;
    f_r1   = resp1_if.val & resp1_if.rdy;
    mq_msg = mreq_if.msg;
    r0_msg = resp0_if.msg;
    r1_msg = resp1_if.msg;
    if (resp1_if.val) seen_resp1 = 1'b1;
    @(posedge clk);
    #1;
    if (reset) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else begin
      if (f_q0) begin q0.delete(0); grants.push_back(1'b0); end
      if (f_q1) begin q1.delete(0); grants.push_back(1'b1); end
      if (f_mq) mreq_log.push_back(mq_msg);
      if (f_r0) begin rx0.push_back(r0_msg); cnt0_log.push_back(cnt0); end
      if (f_r1) rx1.push_back(r1_msg);
      if (f_mr) m_busy = 1'b0;
      if (f_mq) begin
        m_busy = 1'b1;
        m_cnt  = lp_lat;
        m_prod = 32'(mq_msg[63:32] * mq_msg[31:0]);
      end else if (m_busy && m_cnt > 0) begin
        m_cnt--;
      end
    end
    drive();
    #1;
  endtask

  task automatic wait_rx(input int n0, input int n1, input string tag);
    for (int b = 0; b < 200 && !(rx0.size() >= n0 && rx1.size() >= n1); b++) step();
    check({tag, "_done"}, 64'(rx0.size() >= n0 && rx1.size() >= n1), 64'd1);
  endtask

  task automatic wait_grant(input int n, input string tag);
    for (int b = 0; b < 200 && grants.size() < n; b++) step();
    check({tag, "_grant"}, 64'(grants.size() >= n), 64'd1);
  endtask

  task automatic clear_logs();
    q0.delete(); q1.delete(); mreq_log.delete(); rx0.delete(); rx1.delete();
    grants.delete(); cnt0_log.delete();
    seen_resp1 = 1'b0;
  endtask

  logic [31:0] exp0[4];
  logic [31:0] exp1[4];
  logic [1:0]  exp_wrap[5];
  logic [7:0]  gpat;
  int          bad;

  initial begin
    reset  = 1'b1;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_prod = 32'd0;
    clear_logs();

    // Reset state with a pending request that must not be accepted
    q0.push_back({32'd3, 32'd4});
    drive();
    step();
    step();
    check("rst_req0_rdy",  req0_if.rdy,  0);
    check("rst_req1_rdy",  req1_if.rdy,  0);
    check("rst_mreq_val",  mreq_if.val,  0);
    check("rst_mresp_rdy", mresp_if.rdy, 0);
    check("rst_resp0_val", resp0_if.val, 0);
    check("rst_resp1_val", resp1_if.val, 0);
    check("rst_cnt0",      cnt0,         0);
    check("rst_cnt1",      cnt1,         0);
    seen_resp1 = 1'b0;

    // Single requester
    reset = 1'b0;
    #1;
    wait_rx(1, 0, "single");
    check("single_fwd",    mreq_log[0], 64'h0000000300000004);
    check("single_prod",   rx0[0],      32'd12);
    check("single_no_r1",  seen_resp1,  0);
    check("single_cnt0",   cnt0,        1);
    check("single_cnt1",   cnt1,        0);

    // Simultaneous after reset: requester 0 first
    reset = 1'b1;
    step();
    clear_logs();
    q0.push_back({32'd5, 32'd6});
    q1.push_back({32'd7, 32'd8});
    drive();
    step();
    reset = 1'b0;
    #1;
    wait_rx(1, 1, "simul");
    check("simul_order", {grants[0], grants[1]}, 2'b01);
    check("simul_prod0", rx0[0], 32'd30);
    check("simul_prod1", rx1[0], 32'd56);
    check("simul_cnt0",  cnt0,   1);
    check("simul_cnt1",  cnt1,   1);

    // Sustained contention, counters are 2 bits wide
    clear_logs();
    q0.push_back({32'hFFFFFFFF, 32'd2});   exp0[0] = 32'hFFFFFFFE;
    q0.push_back({32'd10, 32'd10});        exp0[1] = 32'd100;
    q0.push_back({32'h10000, 32'h10000});  exp0[2] = 32'd0;
    q0.push_back({32'd123, 32'd456});      exp0[3] = 32'd56088;
    q1.push_back({32'd7, 32'd7});          exp1[0] = 32'd49;
    q1.push_back({32'hFFFF, 32'hFFFF});    exp1[1] = 32'hFFFE0001;
    q1.push_back({32'd1000, 32'd1000});    exp1[2] = 32'd1000000;
    q1.push_back({32'd0, 32'd99});         exp1[3] = 32'd0;
    drive();
    wait_rx(4, 4, "cont");
    gpat = 8'd0;
    for (int i = 0; i < 8 && i < grants.size(); i++) gpat = {gpat[6:0], grants[i]};
    check("cont_ngrants", grants.size(), 8);
    check("cont_order",   gpat, 8'b01010101);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_prod0_%0d", i), rx0[i], exp0[i]);
      check($sformatf("cont_prod1_%0d", i), rx1[i], exp1[i]);
    end
    check("cont_cnt0", cnt0, 1);
    check("cont_cnt1", cnt1, 1);

    // Response back-pressure on requester 1
    clear_logs();
    rdy1 = 1'b0;
    q1.push_back({32'd6, 32'd7});
    drive();
    wait_grant(1, "bp");
    q0.push_back({32'd2, 32'd3});
    drive();
    #1;
    for (int b = 0; b < 50 && !resp1_if.val; b++) step();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!resp1_if.val || mresp_if.rdy || req0_if.rdy) bad++;
      step();
    end
    check("bp_hold",    bad,        0);
    check("bp_no_resp", rx1.size(), 0);
    rdy1 = 1'b1;
    drive();
    #1;
    wait_rx(1, 1, "bp");
    check("bp_prod1", rx1[0], 32'd42);
    check("bp_prod0", rx0[0], 32'd6);
    check("bp_order", {grants[0], grants[1]}, 2'b10);
    check("bp_cnt0",  cnt0, 2);
    check("bp_cnt1",  cnt1, 2);

    // Reset while requester 1 owns the multiplier
    clear_logs();
    rdy1 = 1'b0;
    q1.push_back({32'd4, 32'd4});
    drive();
    wait_grant(1, "rmid");
    step();
    step();
    reset = 1'b1;
    #1;
    check("rmid_resp1_val", resp1_if.val, 0);
    check("rmid_mresp_rdy", mresp_if.rdy, 0);
    q1.push_back({32'd2, 32'd9});
    drive();
    step();
    check("rmid_req1_rdy", req1_if.rdy, 0);
    check("rmid_req0_rdy", req0_if.rdy, 0);
    check("rmid_mreq_val", mreq_if.val, 0);
    check("rmid_cnt0",     cnt0,        0);
    check("rmid_cnt1",     cnt1,        0);
    reset = 1'b0;
    #1;
    check("rmid_idle_rdy", req1_if.rdy, 1);
    rdy1 = 1'b1;
    drive();
    #1;
    wait_rx(0, 1, "rmid");
    check("rmid_prod", rx1[0], 32'd18);
    check("rmid_cnt1_after", cnt1, 1);

    // Counter wrap with 2-bit counters
    reset = 1'b1;
    step();
    clear_logs();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) q0.push_back({32'(i), 32'(i)});
    exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3;
    exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;
    drive();
    #1;
    wait_rx(5, 0, "wrap");
    for (int i = 0; i < 5; i++) check($sformatf("wrap_cnt0_%0d", i), cnt0_log[i], exp_wrap[i]);
    check("wrap_last_prod", rx0[4], 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imul_share_arbiter.md
Name: imul_share_arbiter

Overview:
- Shares one val/rdy integer multiplier (64-bit request = {a,b}, 32-bit response) between two independent requester ports.
- Sits between two client val/rdy channels and a single multiplier instance.
- Round-robin grant, one transaction in flight at a time; the response is routed back to the owning requester.
- Keeps per-requester completion counters for performance tracing.

Parameters:
p_nbits  32  operand/result width; request message is 2*p_nbits
p_cnt_nbits  16  width of per-requester completion counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req0_val  input  1  requester 0 request valid
req0_rdy  output  1  requester 0 request ready
req0_msg  input  2*p_nbits  requester 0 operands {a,b}
resp0_val  output  1  response valid to requester 0
resp0_rdy  input  1  requester 0 response ready
resp0_msg  output  p_nbits  product to requester 0
req1_val/req1_rdy/req1_msg, resp1_val/resp1_rdy/resp1_msg  as above, requester 1
mul_req_val  output  1  request valid to multiplier
mul_req_rdy  input  1  multiplier request ready
mul_req_msg  output  2*p_nbits  operands forwarded to multiplier
mul_resp_val  input  1  multiplier response valid
mul_resp_rdy  output  1  response ready to multiplier
mul_resp_msg  input  p_nbits  multiplier product
cnt0  output  p_cnt_nbits  completed transactions, requester 0
cnt1  output  p_cnt_nbits  completed transactions, requester 1

Behaviour:
- Clocking: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, owner=0, prio=0 (requester 0 favoured), cnt0=cnt1=0.
- During reset: all rdy/val outputs are forced to 0 combinationally.
- States: IDLE, WAIT.
- IDLE, grant selection (combinational):
  - grant = the only valid requester; if both are valid, grant = prio.
  - mul_req_val = reqG_val; mul_req_msg = reqG_msg.
  - reqG_rdy = mul_req_rdy; the other req_rdy = 0.
  - With no valid requester: mul_req_val=0, mul_req_msg=0.
  - mul_resp_rdy=0; resp0_val=resp1_val=0.
- IDLE -> WAIT on the mul_req fire (mul_req_val & mul_req_rdy):
  - owner <= grant; prio <= ~grant.
  - The grant is recomputed each IDLE cycle until fire; no latching before fire.
- WAIT:
  - req0_rdy=req1_rdy=0; mul_req_val=0.
  - resp[owner]_val = mul_resp_val; resp[owner]_msg = mul_resp_msg.
  - mul_resp_rdy = resp[owner]_rdy; the non-owner resp_val=0.
  - resp_msg of the non-owner is 0.
- WAIT -> IDLE on the mul_resp fire; cnt[owner] increments in the same edge.
  - Counters wrap modulo 2^p_cnt_nbits.
- No combinational path from resp*_rdy to req*_rdy. The only pass-throughs are the ones listed above.
- Minimum occupancy per transaction: 1 IDLE cycle + multiplier latency + 1 response cycle.
  - A new request is accepted at the earliest in the cycle after the response fire.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Requester back-pressure: if resp[owner]_rdy=0, the block stays in WAIT and mul_resp_rdy=0, stalling the multiplier. The other requester is not served meanwhile.
- The non-owner requester may raise and hold val in WAIT; it is ignored until IDLE.
- Request val dropping before fire is allowed; no grant state is consumed.
- Reset mid-transaction: returns to IDLE and drops the in-flight transaction. The multiplier shares the same reset.
- Product width: p_nbits LSBs exactly as produced by the multiplier; no modification.

Test Plan:
- Single requester: req0 {32'd3, 32'd4} -> mul_req_msg=0x0000000300000004 forwarded; resp0_msg=12, resp1_val stays 0, cnt0=1.
- Simultaneous after reset: req0 {5,6} and req1 {7,8} valid in the same cycle -> req0 granted first (resp0=30), then req1 (resp1=56); prio ends at 0; cnt0=cnt1=1.
- Sustained contention: 4 requests queued on each port -> grant order 0,1,0,1,0,1,0,1; results correct, including signed case 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Response back-pressure: resp1_rdy=0 for 5 cycles while owner=1 -> state held in WAIT, mul_resp_rdy=0, req0_rdy=0 throughout; completes on the rdy assertion.
- Reset mid-WAIT: reset asserted while owner=1 -> next cycle IDLE, cnt0=cnt1=0, all val/rdy 0 during reset; a following req1 {2,9} returns 18.
- Counter wrap (p_cnt_nbits=2): 5 requests on req0 -> cnt0 sequence 1,2,3,0,1.
